recv_buf_core: RTL and testbench

Byte-wide receive buffer core for the Ethernet receiver subsystem: an asynchronous-read byte RAM, a nibble-enabled tri-state bus driver, and a 7474-style status flip-flop (frame-received flag) in one clocked block. The block sits between the receiver's byte stream and the CPU data bus `d`. Optional contention checking flags illegal enable combinations.

---
 rtl/recv_buf_core.sv | 106 ++++++++++
 tb/tb_recv_buf_core.sv | 137 +++++++++++++
 2 files changed

// File: rtl/recv_buf_core.sv
// Receive buffer core: async-read byte RAM, nibble-enabled bus driver and 7474-style frame flag.
// Define RECV_BUF_CONTENTION_CHECK_EN to enable the sticky bus/RAM contention flag on err.
module recv_buf_core #(
   parameter int          A_WIDTH       = 11,
   parameter logic [7:0]  INITIAL_VALUE = 8'd0
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic [A_WIDTH-1:0] a,
   input  logic [7:0]         wd,
   input  logic               n_cs,
   input  logic               n_oe,
   input  logic               n_we,
   input  logic               n_oe1,
   input  logic               n_oe2,
   input  logic               n_ff_oe,
   inout  wire  [7:0]         d,
   input  logic               ff_d,
   input  logic               ff_cp,
   input  logic               ff_n_cd,
   input  logic               ff_n_sd,
   output logic               ff_q,
   output logic               ff_n_q,
   output logic               err
);

   logic [7:0] mem [0:(2**A_WIDTH)-1] = '{default: INITIAL_VALUE};
   logic [7:0] rdata;
   logic       cp_prev;
   logic [3:0] lo_val, hi_val;
   logic       lo_en, hi_en;

   // n_rst is active-high here: writes only happen while it is low
   always_ff @(posedge clk) begin
      if (!n_rst && !n_cs && !n_we)
         mem[a] <= wd;
   end

   always_comb begin
      rdata = 8'hFF;
      if (!n_cs && !n_oe && n_we)
         rdata = mem[a];
   end

   // Flag driver takes the bus when enabled; overlap with n_oe1/n_oe2 is flagged by err
   always_comb begin
      lo_en  = 1'b0;
      hi_en  = 1'b0;
      lo_val = rdata[3:0];
      hi_val = rdata[7:4];
      if (!n_ff_oe) begin
         lo_en  = 1'b1;
         hi_en  = 1'b1;
         lo_val = {3'b000, ff_q};
         hi_val = 4'h0;
      end else begin
         lo_en = !n_oe1;
         hi_en = !n_oe2;
      end
   end

   assign d[3:0] = lo_en ? lo_val : 4'bzzzz;
   assign d[7:4] = hi_en ? hi_val : 4'bzzzz;

   always_ff @(posedge clk) begin
      if (n_rst) begin
         ff_q    <= 1'b0;
         ff_n_q  <= 1'b1;
         cp_prev <= 1'b0;
      end else begin
         cp_prev <= ff_cp;
         if (!ff_n_cd && !ff_n_sd) begin
            ff_q   <= 1'b1;
            ff_n_q <= 1'b1;
         end else if (!ff_n_cd) begin
            ff_q   <= 1'b0;
            ff_n_q <= 1'b1;
         end else if (!ff_n_sd) begin
            ff_q   <= 1'b1;
            ff_n_q <= 1'b0;
         end else if (ff_cp && !cp_prev) begin
            ff_q   <= ff_d;
            ff_n_q <= ~ff_d;
         end
      end
   end

`ifdef RECV_BUF_CONTENTION_CHECK_EN
   logic contention;
   assign contention = (!n_ff_oe && (!n_oe1 || !n_oe2)) || (!n_cs && !n_oe && !n_we);

   always_ff @(posedge clk) begin
      if (n_rst) begin
         err <= 1'b0;
      end else if (contention) begin
         err <= 1'b1;
`ifndef SYNTHESIS
         $display("recv_buf_core: enable contention at time %0t", $time);
`endif
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_recv_buf_core.sv
// Directed bench for recv_buf_core: RAM, nibble driver, flag flip-flop and contention flag.
module tb_recv_buf_core;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [10:0] a;
   logic [7:0]  wd;
   logic        n_cs, n_oe, n_we, n_oe1, n_oe2, n_ff_oe;
   logic        ff_d, ff_cp, ff_n_cd, ff_n_sd;
   logic        ff_q, ff_n_q, err;
   wire  [7:0]  d;

   // Bench-side probe drivers: a value seen intact on d proves the DUT left that nibble floating
   logic        tb_en_lo, tb_en_hi;
   logic [7:0]  tb_dat;
   assign d[3:0] = tb_en_lo ? tb_dat[3:0] : 4'bzzzz;
   assign d[7:4] = tb_en_hi ? tb_dat[7:4] : 4'bzzzz;

   int checks = 0;
   int errors = 0;

   recv_buf_core #(.A_WIDTH(11), .INITIAL_VALUE(8'd38)) dut (
      .clk(clk), .n_rst(n_rst), .a(a), .wd(wd),
      .n_cs(n_cs), .n_oe(n_oe), .n_we(n_we),
      .n_oe1(n_oe1), .n_oe2(n_oe2), .n_ff_oe(n_ff_oe),
      .d(d), .ff_d(ff_d), .ff_cp(ff_cp), .ff_n_cd(ff_n_cd), .ff_n_sd(ff_n_sd),
      .ff_q(ff_q), .ff_n_q(ff_n_q), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic exp_err;

   initial begin
`ifdef RECV_BUF_CONTENTION_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      n_rst = 1'b1; a = '0; wd = '0;
      n_cs = 1; n_oe = 1; n_we = 1; n_oe1 = 1; n_oe2 = 1; n_ff_oe = 1;
      ff_d = 0; ff_cp = 0; ff_n_cd = 1; ff_n_sd = 1;
      tb_en_lo = 0; tb_en_hi = 0; tb_dat = 8'h00;
      tick(); tick();

      check("rst_q",   {7'b0, ff_q},   8'h00);
      check("rst_nq",  {7'b0, ff_n_q}, 8'h01);
      check("rst_err", {7'b0, err},    8'h00);
      tb_en_lo = 1; tb_en_hi = 1; tb_dat = 8'h5A; #1;
      check("rst_bus_float", d, 8'h5A);
      tb_en_lo = 0; tb_en_hi = 0;

      n_rst = 0;
      tick();

      // Power-up content
      a = 11'h7FF; n_cs = 0; n_oe = 0; n_we = 1; n_oe1 = 0; n_oe2 = 0; #1;
      check("powerup_7ff", d, 8'd38);

      // Write 0xA5 to 0x123; read path returns FF while n_we is low
      a = 11'h123; wd = 8'hA5; n_oe = 1; n_we = 0; #1;
      check("during_write", d, 8'hFF);
      tick();
      n_we = 1; n_oe = 0; #1;
      check("readback_123", d, 8'hA5);
      a = 11'h124; #1;
      check("neighbour_124", d, 8'd38);
      a = 11'h123;

      n_oe2 = 1; tb_en_hi = 1; tb_dat = 8'h30; #1;
      check("hi_nibble_float", d, 8'h35);
      n_oe1 = 1; tb_en_lo = 1; tb_dat = 8'h5A; #1;
      check("both_float", d, 8'h5A);
      tb_en_lo = 0; tb_en_hi = 0;

      // Flip-flop rising edge captures ff_d
      ff_d = 1; ff_cp = 1;
      tick(); tick();
      check("cp_edge_q",  {7'b0, ff_q},   8'h01);
      check("cp_edge_nq", {7'b0, ff_n_q}, 8'h00);
      ff_d = 0; tick();
      check("cp_high_hold", {7'b0, ff_q}, 8'h01);
      ff_cp = 0;

      ff_n_cd = 0; tick(); ff_n_cd = 1;
      check("clear_q",  {7'b0, ff_q},   8'h00);
      check("clear_nq", {7'b0, ff_n_q}, 8'h01);

      ff_n_sd = 0; tick(); ff_n_sd = 1;
      check("set_q",  {7'b0, ff_q},   8'h01);
      check("set_nq", {7'b0, ff_n_q}, 8'h00);

      ff_n_cd = 0; ff_n_sd = 0; tick();
      check("both_q",  {7'b0, ff_q},   8'h01);
      check("both_nq", {7'b0, ff_n_q}, 8'h01);
      ff_n_cd = 1; ff_n_sd = 1; tick();
      check("release_hold", {6'b0, ff_q, ff_n_q}, 8'h03);

      // Flag read with q=1
      n_cs = 1; n_oe = 1; n_oe1 = 1; n_oe2 = 1; n_ff_oe = 0; #1;
      check("flag_read", d, 8'h01);
      n_ff_oe = 1;

      // Reset clears the flop; writes during reset are ignored
      n_rst = 1; a = 11'h200; wd = 8'h77; n_cs = 0; n_we = 0; tick();
      check("rst2_q",  {7'b0, ff_q},   8'h00);
      check("rst2_nq", {7'b0, ff_n_q}, 8'h01);
      n_rst = 0; n_we = 1; n_oe = 0; n_oe1 = 0; n_oe2 = 0; #1;
      check("write_in_rst_dropped", d, 8'd38);
      a = 11'h123; #1;
      check("mem_kept_after_rst", d, 8'hA5);

      // Contention: flag driver overlapping the low nibble driver
      n_cs = 1; n_oe = 1; n_oe2 = 1; n_ff_oe = 0; tick();
      n_ff_oe = 1; n_oe1 = 1; tick();
      check("err_sticky", {7'b0, err}, {7'b0, exp_err});
      n_rst = 1; tick(); n_rst = 0;
      check("err_rst", {7'b0, err}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
